// File: rtl/audio_pkg.sv
// Shared audio definitions for the codec serial link (ADC capture and DAC transmit paths).
package audio_pkg;

    // Native sample width of the audio datapath
    localparam int AUDIO_DATA_W = 24;

    // LRCK level that identifies each channel slot
    localparam logic I2S_CH_LEFT  = 1'b0;
    localparam logic I2S_CH_RIGHT = 1'b1;

    // Capture shifter states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_WAIT  = 2'd2
    } rx_state_e;

    // One stereo sample pair, left word in the upper half
    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } stereo_pair_t;

endpackage

// File: rtl/audio_i2s_adc_rx_if.sv
// Stereo sample stream from the capture block towards the processing side.
interface audio_i2s_adc_rx_if #(
    parameter int DATA_W = 24
) ();

    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO holding stereo pairs; a push into a full FIFO is
// only accepted when a pop frees a slot in the same cycle.
module audio_sample_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/audio_i2s_adc_rx.sv
// I2S ADC capture: synchronises the codec pins, shifts left/right words MSB first,
// pairs them (pairs always start with a left word) and queues pairs in a FIFO.
module audio_i2s_adc_rx
    import audio_pkg::*;
#(
    parameter  int DATA_W     = 24,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 enable,
    input  logic                 audio_BCLK,
    input  logic                 audio_ADCLRCK,
    input  logic                 audio_ADCDAT,
    audio_i2s_adc_rx_if.master   smp,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MSB_ONLY = DATA_W'(1) << (DATA_W - 1);

    logic              bclk_meta_q, bclk_s_q, bclk_q;
    logic              lrck_meta_q, lrck_s_q, lrck_q;
    logic              dat_meta_q, dat_s_q;
    logic              rise;
    logic              lrck_edge;

    rx_state_e         state_q;
    logic              chan_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] bit_mask;

    logic              commit_q;
    logic              commit_chan_q;
    logic [DATA_W-1:0] word_q;

    logic [DATA_W-1:0]   left_hold_q;
    logic                left_ok_q;
    logic                push_q;
    logic [2*DATA_W-1:0] pair_q;

    logic [2*DATA_W-1:0] fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;

    // Two-flop synchronisers for the codec pins plus the BCLK history flop
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_meta_q <= 1'b0;
            bclk_s_q    <= 1'b0;
            bclk_q      <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_s_q    <= 1'b0;
            dat_meta_q  <= 1'b0;
            dat_s_q     <= 1'b0;
        end else begin
            bclk_meta_q <= audio_BCLK;
            bclk_s_q    <= bclk_meta_q;
            bclk_q      <= bclk_s_q;
            lrck_meta_q <= audio_ADCLRCK;
            lrck_s_q    <= lrck_meta_q;
            dat_meta_q  <= audio_ADCDAT;
            dat_s_q     <= dat_meta_q;
        end
    end

    assign rise      = bclk_s_q & ~bclk_q;
    assign lrck_edge = (lrck_s_q != lrck_q);

    // Words are built MSB first into a cleared register, so a short slot ends
    // up left-justified with zero LSBs without any final realignment
    assign bit_mask = MSB_ONLY >> bit_cnt_q;
    assign shreg_d  = dat_s_q ? (shreg_q | bit_mask) : shreg_q;

    // Capture FSM: steps on BCLK rises and hands finished words to the pairing stage
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= RX_IDLE;
            chan_q        <= I2S_CH_LEFT;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            lrck_q        <= 1'b0;
            commit_q      <= 1'b0;
            commit_chan_q <= I2S_CH_LEFT;
            word_q        <= '0;
        end else begin
            commit_q <= 1'b0;
            if (rise) lrck_q <= lrck_s_q;
            if (!enable) begin
                state_q   <= RX_IDLE;
                bit_cnt_q <= '0;
                shreg_q   <= '0;
            end else if (rise) begin
                case (state_q)
                    RX_IDLE: begin
                        if (lrck_edge) begin
                            state_q   <= RX_SHIFT;
                            chan_q    <= lrck_s_q;
                            bit_cnt_q <= '0;
                            shreg_q   <= '0;
                        end
                    end
                    RX_SHIFT: begin
                        if (lrck_edge) begin
                            word_q        <= shreg_d;
                            commit_chan_q <= chan_q;
                            commit_q      <= 1'b1;
                            chan_q        <= lrck_s_q;
                            bit_cnt_q     <= '0;
                            shreg_q       <= '0;
                        end else begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == LAST_CNT) begin
                                word_q        <= shreg_d;
                                commit_chan_q <= chan_q;
                                commit_q      <= 1'b1;
                                state_q       <= RX_WAIT;
                            end
                        end
                    end
                    RX_WAIT: begin
                        if (lrck_edge) begin
                            state_q   <= RX_SHIFT;
                            chan_q    <= lrck_s_q;
                            bit_cnt_q <= '0;
                            shreg_q   <= '0;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // Pairing: hold a left word until its right partner arrives; orphan rights are dropped
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            push_q      <= 1'b0;
            pair_q      <= '0;
        end else begin
            push_q <= 1'b0;
            if (!enable) begin
                left_ok_q <= 1'b0;
            end else if (commit_q) begin
                if (commit_chan_q == I2S_CH_LEFT) begin
                    left_hold_q <= word_q;
                    left_ok_q   <= 1'b1;
                end else if (left_ok_q) begin
                    push_q    <= 1'b1;
                    pair_q    <= {left_hold_q, word_q};
                    left_ok_q <= 1'b0;
                end
            end
        end
    end

    assign pop = ~fifo_empty & smp.sample_ready;

    audio_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push_q),
        .wdata_i (pair_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign smp.sample_valid = ~fifo_empty;
    assign smp.sample_left  = fifo_rdata[2*DATA_W-1:DATA_W];
    assign smp.sample_right = fifo_rdata[DATA_W-1:0];

    // Sticky overflow: a dropped pair wins over a simultaneous clear request
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow <= 1'b0;
        end else if (push_q & fifo_full & ~pop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_i2s_adc_rx.sv
// Bench for the I2S ADC capture block: a behavioural codec drives the serial pins
// and expected pairs come from left-justifying each slot word.
module tb_audio_i2s_adc_rx;
    import audio_pkg::*;

    localparam int DATA_W   = 24;
    localparam int HALF_BIT = 80;
    localparam int N_RAND   = 8;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       enable        = 1'b0;
    logic       audio_BCLK    = 1'b0;
    logic       audio_ADCLRCK = 1'b0;
    logic       audio_ADCDAT  = 1'b0;
    logic       overflow_clr  = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;

    audio_i2s_adc_rx_if #(.DATA_W(DATA_W)) smp ();

    audio_i2s_adc_rx #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .audio_BCLK    (audio_BCLK),
        .audio_ADCLRCK (audio_ADCLRCK),
        .audio_ADCDAT  (audio_ADCDAT),
        .smp           (smp.master),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    // 100 MHz system clock
    always #5 clk_clk = ~clk_clk;

    int           assertCount = 0;
    int           failCount   = 0;
    logic         prevLsb     = 1'b0;
    bit           markArm     = 1'b0;
    event         bit24Rise;
    int           latencyCnt;
    int           got;
    int           cyc;
    int           slotBits;
    stereo_pair_t expQ [$];
    stereo_pair_t expPair;
    logic [31:0]  lw [5];
    logic [31:0]  rw [5];

    // Compare one observed value with the expected one and record the outcome
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // A slot word is MSB first; the captured word is its top DATA_W bits, zero-filled if shorter
    function automatic logic [DATA_W-1:0] leftJustify(input logic [31:0] slotWord, input int bits);
        logic [31:0] aligned;
        aligned = slotWord << (32 - bits);
        return aligned[31 -: DATA_W];
    endfunction

    // Codec model: one LRCK slot, data changes on BCLK fall, one-bit delay after the LRCK edge
    task automatic applyStimulus(input int bits, input logic ch, input logic [31:0] word);
        for (int i = 0; i < bits; i++) begin
            audio_ADCLRCK = ch;
            audio_ADCDAT  = (i == 0) ? prevLsb : word[bits - i];
            #HALF_BIT audio_BCLK = 1'b1;
            if (markArm && ch == 1'b1 && i == 24) begin
                markArm = 1'b0;
                ->bit24Rise;
            end
            #HALF_BIT audio_BCLK = 1'b0;
        end
        prevLsb = word[0];
    endtask

    task automatic sendFrame(input int bits, input logic [31:0] l, input logic [31:0] r);
        applyStimulus(bits, I2S_CH_LEFT, l);
        applyStimulus(bits, I2S_CH_RIGHT, r);
    endtask

    // Check the FIFO head against an expected pair, then pop it
    task automatic popAndCheck(input string tag, input logic [DATA_W-1:0] expL, input logic [DATA_W-1:0] expR);
        @(negedge clk_clk);
        checkOutput({tag, "_valid"}, smp.sample_valid, 1);
        checkOutput({tag, "_left"}, smp.sample_left, expL);
        checkOutput({tag, "_right"}, smp.sample_right, expR);
        smp.sample_ready = 1'b1;
        @(posedge clk_clk);
        #1 smp.sample_ready = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // Safety net so the run always ends
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        smp.sample_ready = 1'b0;
        #23;
        checkOutput("rst_valid", smp.sample_valid, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_left", smp.sample_left, 0);
        @(negedge clk_clk) reset_reset_n = 1'b1;
        settle(3);

        // 32-bit slots, extra bits ignored, fixed capture latency
        $display("[TB] 32-bit slot capture and latency");
        enable = 1'b1;
        applyStimulus(32, I2S_CH_RIGHT, 32'h0);
        fork
            begin
                markArm = 1'b1;
                sendFrame(32, 32'hA5A5A5A5, 32'h5A5A5A5A);
            end
            begin
                latencyCnt = 0;
                @(bit24Rise);
                do begin
                    @(posedge clk_clk);
                    latencyCnt++;
                    #1;
                end while (!smp.sample_valid && latencyCnt < 20);
                checkOutput("t2_latency", latencyCnt, 5);
            end
        join
        popAndCheck("t2", 24'hA5A5A5, 24'h5A5A5A);
        checkOutput("t2_level_after_pop", fifo_level, 0);
        enable = 1'b0;
        settle(4);

        // 16-bit slots land left-justified with zero LSBs
        $display("[TB] 16-bit slot capture");
        enable = 1'b1;
        applyStimulus(16, I2S_CH_RIGHT, 32'h0);
        sendFrame(16, 32'h1234, 32'h8001);
        applyStimulus(16, I2S_CH_LEFT, 32'h0);
        settle(8);
        popAndCheck("t3", 24'h123400, 24'h800100);
        enable = 1'b0;
        settle(4);

        // Five frames with no consumer: four kept in order, fifth dropped
        $display("[TB] overflow with stalled consumer");
        enable = 1'b1;
        applyStimulus(32, I2S_CH_RIGHT, 32'h0);
        for (int k = 0; k < 5; k++) begin
            lw[k] = $urandom;
            rw[k] = $urandom;
            sendFrame(32, lw[k], rw[k]);
        end
        settle(10);
        checkOutput("t4_level_full", fifo_level, 4);
        checkOutput("t4_overflow_set", overflow, 1);
        for (int k = 0; k < 4; k++)
            popAndCheck($sformatf("t4_pop%0d", k), leftJustify(lw[k], 32), leftJustify(rw[k], 32));
        #1;
        checkOutput("t4_empty_after_drain", smp.sample_valid, 0);
        checkOutput("t4_overflow_sticky", overflow, 1);
        @(negedge clk_clk) overflow_clr = 1'b1;
        @(posedge clk_clk);
        #1 overflow_clr = 1'b0;
        checkOutput("t4_overflow_cleared", overflow, 0);

        // Full FIFO: a pair landing in the same cycle as a pop is accepted
        $display("[TB] push and pop together while full");
        for (int k = 0; k < 4; k++) begin
            lw[k] = $urandom;
            rw[k] = $urandom;
            sendFrame(32, lw[k], rw[k]);
        end
        settle(10);
        checkOutput("t6_level_full", fifo_level, 4);
        lw[4] = $urandom;
        rw[4] = $urandom;
        fork
            begin
                markArm = 1'b1;
                sendFrame(32, lw[4], rw[4]);
            end
            begin
                @(bit24Rise);
                repeat (4) @(posedge clk_clk);
                #1 smp.sample_ready = 1'b1;
                @(posedge clk_clk);
                #1 smp.sample_ready = 1'b0;
            end
        join
        settle(4);
        checkOutput("t6_level_kept", fifo_level, 4);
        checkOutput("t6_no_overflow", overflow, 0);
        for (int k = 1; k < 4; k++)
            popAndCheck($sformatf("t6_pop%0d", k), leftJustify(lw[k], 32), leftJustify(rw[k], 32));
        @(negedge clk_clk);
        checkOutput("t6_last_left", smp.sample_left, leftJustify(lw[4], 32));
        checkOutput("t6_last_right", smp.sample_right, leftJustify(rw[4], 32));
        @(posedge clk_clk);
        #1;

        // Reset in the middle of a slot clears everything at once
        $display("[TB] reset mid-traffic");
        fork
            applyStimulus(32, I2S_CH_LEFT, $urandom);
            begin
                #(HALF_BIT * 20) reset_reset_n = 1'b0;
                #1;
                checkOutput("t1_valid", smp.sample_valid, 0);
                checkOutput("t1_left", smp.sample_left, 0);
                checkOutput("t1_right", smp.sample_right, 0);
                checkOutput("t1_level", fifo_level, 0);
                checkOutput("t1_overflow", overflow, 0);
                #30 reset_reset_n = 1'b1;
            end
        join
        applyStimulus(32, I2S_CH_RIGHT, $urandom);
        applyStimulus(32, I2S_CH_LEFT, $urandom);
        settle(8);
        checkOutput("t1_no_pair_after_reset", fifo_level, 0);

        // Enable raised mid-right waits for the next left; dropped mid-left discards
        $display("[TB] enable gating");
        enable = 1'b0;
        applyStimulus(32, I2S_CH_LEFT, $urandom);
        fork
            applyStimulus(32, I2S_CH_RIGHT, $urandom);
            #(HALF_BIT * 20) enable = 1'b1;
        join
        lw[0] = $urandom;
        rw[0] = $urandom;
        sendFrame(32, lw[0], rw[0]);
        fork
            applyStimulus(32, I2S_CH_LEFT, $urandom);
            #(HALF_BIT * 20) enable = 1'b0;
        join
        applyStimulus(32, I2S_CH_RIGHT, $urandom);
        settle(8);
        checkOutput("t5_level_one", fifo_level, 1);
        popAndCheck("t5", leftJustify(lw[0], 32), leftJustify(rw[0], 32));
        checkOutput("t5_level_empty", fifo_level, 0);

        // Random words and slot widths against a random consumer
        $display("[TB] randomized traffic");
        case ($urandom_range(0, 2))
            0:       slotBits = 16;
            1:       slotBits = 24;
            default: slotBits = 32;
        endcase
        for (int k = 0; k < N_RAND; k++) begin
            expPair.left  = $urandom;
            expPair.right = $urandom;
            expQ.push_back(expPair);
        end
        enable = 1'b1;
        got = 0;
        cyc = 0;
        fork
            begin
                applyStimulus(slotBits, I2S_CH_RIGHT, 32'h0);
                foreach (expQ[k]) begin
                    logic [31:0] lv, rv;
                    lv = 32'(expQ[k].left) >> (DATA_W - slotBits);
                    rv = 32'(expQ[k].right) >> (DATA_W - slotBits);
                    if (slotBits > DATA_W) begin
                        lv = {expQ[k].left, 8'hC3};
                        rv = {expQ[k].right, 8'h3C};
                    end
                    expQ[k].left  = leftJustify(lv, slotBits);
                    expQ[k].right = leftJustify(rv, slotBits);
                    sendFrame(slotBits, lv, rv);
                end
                applyStimulus(slotBits, I2S_CH_LEFT, 32'h0);
            end
            begin
                while (got < N_RAND && cyc < 20000) begin
                    @(negedge clk_clk);
                    cyc++;
                    smp.sample_ready = ($urandom_range(0, 1) == 1);
                    if (smp.sample_valid && smp.sample_ready) begin
                        if (expQ.size() > got) begin
                            checkOutput($sformatf("rnd%0d_left", got), smp.sample_left, expQ[got].left);
                            checkOutput($sformatf("rnd%0d_right", got), smp.sample_right, expQ[got].right);
                        end
                        got++;
                    end
                end
                smp.sample_ready = 1'b0;
            end
        join
        checkOutput("rnd_all_received", got, N_RAND);
        settle(4);
        checkOutput("rnd_no_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
